input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive clocks a new synchronized level must hold before acceptance (legal 2..65535).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, meaning clocks per timer tick, 1 Hz at 50 MHz (legal 2..2^26).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state on its rising edge.
REQ-004 SHALL have port Reset, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port Sensor_raw, input, 1, asynchronous side-street car sensor.
REQ-006 SHALL have port Walk_raw, input, 1, asynchronous pedestrian push-button.
REQ-007 SHALL have port Reprogram_raw, input, 1, asynchronous reprogram push-button.
REQ-008 SHALL have port Walk_Ack, input, 1, one-cycle pulse from the downstream controller FSM when the walk request has been served.
REQ-009 SHALL have port Sensor, output, 1, conditioned sensor level.
REQ-010 SHALL have port Walk_Request, output, 1, latched pedestrian request, held until acknowledged.
REQ-011 SHALL have port Reprogram, output, 1, one-cycle pulse per accepted button press.
REQ-012 SHALL have port Tick, output, 1, one-cycle timer-enable pulse every TICK_DIV clocks.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Per input, a debounce counter SHALL increment each clock the synchronized value differs from the accepted value and clear to 0 each clock they match.
REQ-015 Accepted value SHALL take the synchronized value, and the counter SHALL clear, on the clock the counter would reach DEBOUNCE_CYCLES; raw-to-accepted latency = 2 + DEBOUNCE_CYCLES clocks for a clean step.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized clocks SHALL leave the accepted value unchanged.
REQ-017 Sensor SHALL equal the accepted sensor value, registered, with no further processing.
REQ-018 Walk_Request SHALL be set on the clock after a 0->1 transition of the accepted walk value and cleared on the clock after Walk_Ack=1.
REQ-019 Simultaneous accepted-walk rising edge and Walk_Ack SHALL leave Walk_Request=1 (set wins; no request lost).
REQ-020 Walk_Ack while Walk_Request=0 SHALL have no effect; repeated presses while set SHALL keep it at 1.
REQ-021 Reprogram SHALL be high for exactly one clock following each 0->1 transition of the accepted reprogram value; a held button SHALL produce one pulse only.
REQ-022 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; Tick SHALL be 1 exactly in the cycle the count equals TICK_DIV-1, independent of all other inputs.

Reset
REQ-023 Reset=1 SHALL immediately clear synchronizers, accepted values, debounce counters, tick counter and all outputs to 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; after release a raw input held at 1 SHALL be treated as a new 0->1 edge after the full REQ-015 latency.
REQ-025 First Tick after Reset release SHALL occur in the TICK_DIV-th clock after release.

Configuration
REQ-026 With macro INPUT_CONDITIONER_DEBOUNCE_EN defined, debouncing SHALL follow REQ-014..REQ-016.
REQ-027 Without INPUT_CONDITIONER_DEBOUNCE_EN, debounce counters SHALL not exist, the accepted value SHALL be the synchronizer output (latency 2 clocks), DEBOUNCE_CYCLES SHALL be ignored, and all other requirements SHALL hold unchanged.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5, macro defined unless noted)
REQ-028 Reset release, all raw=0 -> all outputs 0; Tick high on clocks 5, 10, 15 after release, low otherwise.
REQ-029 Sensor_raw 0->1 held -> Sensor rises exactly 6 clocks later; Sensor_raw 3-clock pulse -> Sensor stays 0.
REQ-030 Walk_raw pressed 10 clocks -> Walk_Request=1 after 7 clocks and stays high after release; Walk_Ack pulse -> 0 next clock; new accepted edge coincident with Walk_Ack -> stays 1.
REQ-031 Reprogram_raw held 50 clocks -> exactly one Reprogram pulse of width 1, 7 clocks after press.
REQ-032 Reset asserted 2 clocks into Walk_raw debounce, raw kept high -> outputs 0 immediately; Walk_Request=1 7 clocks after release.
REQ-033 Macro undefined: Sensor_raw 1-clock pulse -> Sensor 1-clock pulse 2 clocks later.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: front end for a traffic-light controller.
// Three asynchronous raw inputs (car sensor, walk button, reprogram button)
// are synchronized, optionally debounced, and turned into the levels and
// pulses the controller FSM consumes, plus a free-running timer tick.
// Optional feature macro: INPUT_CONDITIONER_DEBOUNCE_EN enables the debounce
// counters; without it the accepted value is the synchronizer output.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 50000000
) (
    input  logic clk,
    input  logic Reset,
    input  logic Sensor_raw,
    input  logic Walk_raw,
    input  logic Reprogram_raw,
    input  logic Walk_Ack,
    output logic Sensor,
    output logic Walk_Request,
    output logic Reprogram,
    output logic Tick
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // bit 0 = sensor, bit 1 = walk, bit 2 = reprogram
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    acc;
    logic [2:0]    acc_d;
    logic [2:0]    rise;
    logic [TW-1:0] tick_cnt;

    assign raw = {Reprogram_raw, Walk_raw, Sensor_raw};

    // Two-flop synchronizer for all raw inputs
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0] db_cnt [3];

    // Debounce: a new level is accepted once it has differed from the
    // accepted value for DEBOUNCE_CYCLES consecutive clocks
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            acc <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign acc = sync2;
`endif

    // Previous accepted value, for rising-edge detection
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            acc_d <= '0;
        end else begin
            acc_d <= acc;
        end
    end

    assign rise   = acc & ~acc_d;
    assign Sensor = acc[0];

    // Walk request latch: a new press wins over a simultaneous acknowledge
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Walk_Request <= 1'b0;
        end else if (rise[1]) begin
            Walk_Request <= 1'b1;
        end else if (Walk_Ack) begin
            Walk_Request <= 1'b0;
        end
    end

    // One-clock reprogram pulse per accepted press
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Reprogram <= 1'b0;
        end else begin
            Reprogram <= rise[2];
        end
    end

    // Free-running tick divider, wraps at TICK_DIV-1
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            tick_cnt <= '0;
            Tick     <= 1'b0;
        end else begin
            Tick <= (tick_cnt == TW'(TICK_DIV - 1));
            if (tick_cnt == TW'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Reference model works from the history of raw samples: a level is accepted
// once the synchronized samples in the last DEBOUNCE_CYCLES clocks all differ
// from the current accepted value.
module tb_input_conditioner;
    localparam int DB = 4;
    localparam int TD = 5;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int ACC_LAT = 2 + DB;
    localparam bit DB_EN   = 1'b1;
`else
    localparam int ACC_LAT = 2;
    localparam bit DB_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic Sensor_raw = 1'b0;
    logic Walk_raw = 1'b0;
    logic Reprogram_raw = 1'b0;
    logic Walk_Ack = 1'b0;
    logic Sensor, Walk_Request, Reprogram, Tick;

    int checks = 0;
    int passes = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk(clk), .Reset(Reset),
        .Sensor_raw(Sensor_raw), .Walk_raw(Walk_raw),
        .Reprogram_raw(Reprogram_raw), .Walk_Ack(Walk_Ack),
        .Sensor(Sensor), .Walk_Request(Walk_Request),
        .Reprogram(Reprogram), .Tick(Tick)
    );

    always #5 clk = ~clk;

    // reference model state
    bit [63:0] hist [3];
    bit [2:0]  m_acc, m_acc_d;
    bit        m_wr, m_rp, m_tick;
    int        m_edges;

    always @(posedge clk or posedge Reset) begin
        bit [2:0] rawv, rise, nacc;
        bit flip;
        if (Reset) begin
            for (int c = 0; c < 3; c++) hist[c] = '0;
            m_acc = '0; m_acc_d = '0;
            m_wr = 0; m_rp = 0; m_tick = 0; m_edges = 0;
        end else begin
            rawv = {Reprogram_raw, Walk_raw, Sensor_raw};
            for (int c = 0; c < 3; c++) hist[c] = {hist[c][62:0], rawv[c]};
            rise = m_acc & ~m_acc_d;
            if (rise[1]) m_wr = 1;
            else if (Walk_Ack) m_wr = 0;
            m_rp = rise[2];
            for (int c = 0; c < 3; c++) begin
                if (DB_EN) begin
                    flip = 1;
                    for (int i = 2; i <= DB + 1; i++)
                        if (hist[c][i] == m_acc[c]) flip = 0;
                    nacc[c] = flip ? ~m_acc[c] : m_acc[c];
                end else begin
                    nacc[c] = hist[c][1];
                end
            end
            m_acc_d = m_acc;
            m_acc   = nacc;
            m_edges++;
            m_tick = (m_edges % TD == 0);
        end
    end

    function automatic bit [3:0] model_vec();
        return {m_acc[0], m_wr, m_rp, m_tick};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit [3:0] obs;
        #3;
        obs = {Sensor, Walk_Request, Reprogram, Tick};
        checks++;
        if (obs !== 4'b0) $display("FAIL reset_state got %b exp 0000", obs);
        else passes++;
        cyc();
        Reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            checks++;
            if (Tick !== ((k % TD) == 0) || {Sensor, Walk_Request, Reprogram} !== 3'b0)
                $display("FAIL reset_idle k=%0d got %b exp tick=%0b others 0", k,
                         {Sensor, Walk_Request, Reprogram, Tick}, (k % TD) == 0);
            else passes++;
        end
    endtask

    task automatic test_sensor();
        bit [3:0] obs;
        Sensor_raw = 1'b1;
        for (int k = 1; k <= ACC_LAT + 3; k++) begin
            cyc();
            obs = {Sensor, Walk_Request, Reprogram, Tick};
            checks++;
            if (obs !== model_vec() || (k == ACC_LAT - 1 && Sensor !== 1'b0) ||
                (k == ACC_LAT && Sensor !== 1'b1))
                $display("FAIL sensor_step k=%0d got %b exp %b", k, obs, model_vec());
            else passes++;
        end
        Sensor_raw = 1'b0;
        repeat (ACC_LAT + 2) cyc();
        Sensor_raw = 1'b1;
        repeat (3) cyc();
        Sensor_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            obs = {Sensor, Walk_Request, Reprogram, Tick};
            checks++;
            if (obs !== model_vec() || (DB_EN && Sensor !== 1'b0))
                $display("FAIL sensor_glitch k=%0d got %b exp %b", k, obs, model_vec());
            else passes++;
        end
    endtask

    task automatic test_walk();
        bit [3:0] obs;
        Walk_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 11) Walk_raw = 1'b0;
            cyc();
            obs = {Sensor, Walk_Request, Reprogram, Tick};
            checks++;
            if (obs !== model_vec() || (k == ACC_LAT && Walk_Request !== 1'b0) ||
                (k >= ACC_LAT + 1 && Walk_Request !== 1'b1))
                $display("FAIL walk_set k=%0d got %b exp %b", k, obs, model_vec());
            else passes++;
        end
        Walk_Ack = 1'b1;
        cyc();
        Walk_Ack = 1'b0;
        checks++;
        if (Walk_Request !== 1'b0) $display("FAIL walk_ack got %b exp 0", Walk_Request);
        else passes++;
        Walk_Ack = 1'b1;
        cyc();
        Walk_Ack = 1'b0;
        checks++;
        if (Walk_Request !== 1'b0) $display("FAIL walk_ack_idle got %b exp 0", Walk_Request);
        else passes++;
        // press again, acknowledge in the very cycle the accepted edge appears
        Walk_raw = 1'b1;
        repeat (ACC_LAT) cyc();
        Walk_Ack = 1'b1;
        cyc();
        Walk_Ack = 1'b0;
        obs = {Sensor, Walk_Request, Reprogram, Tick};
        checks++;
        if (Walk_Request !== 1'b1 || obs !== model_vec())
            $display("FAIL walk_set_wins got %b exp %b", obs, model_vec());
        else passes++;
        Walk_raw = 1'b0;
        Walk_Ack = 1'b1;
        cyc();
        Walk_Ack = 1'b0;
        repeat (ACC_LAT + 2) cyc();
    endtask

    task automatic test_reprogram();
        bit [3:0] obs;
        int pulses = 0;
        Reprogram_raw = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            cyc();
            obs = {Sensor, Walk_Request, Reprogram, Tick};
            if (Reprogram === 1'b1) pulses++;
            checks++;
            if (obs !== model_vec() || Reprogram !== (k == ACC_LAT + 1))
                $display("FAIL reprogram_pulse k=%0d got %b exp %b", k, obs, model_vec());
            else passes++;
        end
        Reprogram_raw = 1'b0;
        checks++;
        if (pulses != 1) $display("FAIL reprogram_count got %0d exp 1", pulses);
        else passes++;
        repeat (ACC_LAT + 2) cyc();
    endtask

    task automatic test_reset_mid();
        bit [3:0] obs;
        Walk_raw = 1'b1;
        repeat (4) cyc();
        #2;
        Reset = 1'b1;
        #1;
        obs = {Sensor, Walk_Request, Reprogram, Tick};
        checks++;
        if (obs !== 4'b0) $display("FAIL reset_mid_clear got %b exp 0000", obs);
        else passes++;
        cyc();
        cyc();
        Reset = 1'b0;
        for (int k = 1; k <= ACC_LAT + 3; k++) begin
            cyc();
            obs = {Sensor, Walk_Request, Reprogram, Tick};
            checks++;
            if (obs !== model_vec() || Walk_Request !== (k >= ACC_LAT + 1))
                $display("FAIL reset_mid_walk k=%0d got %b exp %b", k, obs, model_vec());
            else passes++;
        end
        Walk_raw = 1'b0;
        Walk_Ack = 1'b1;
        cyc();
        Walk_Ack = 1'b0;
    endtask

    task automatic test_random();
        bit [3:0] obs;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) Sensor_raw = ~Sensor_raw;
            if ($urandom_range(0, 5) == 0) Walk_raw = ~Walk_raw;
            if ($urandom_range(0, 5) == 0) Reprogram_raw = ~Reprogram_raw;
            Walk_Ack = ($urandom_range(0, 7) == 0);
            cyc();
            obs = {Sensor, Walk_Request, Reprogram, Tick};
            checks++;
            if (obs !== model_vec())
                $display("FAIL random k=%0d got %b exp %b", k, obs, model_vec());
            else passes++;
        end
        Walk_Ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sensor();
        test_walk();
        test_reprogram();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
